// File: rtl/score_pkg.sv
// Shared types and helpers for the score controller: game states and
// two-digit BCD score representation.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_DIGIT = 4'hF;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd2_t;

    // Tens digit decides unless equal, then units.
    function automatic logic bcd2_gt(input bcd2_t a, input bcd2_t b);
        if (a.tens != b.tens) begin
            return a.tens > b.tens;
        end
        return a.units > b.units;
    endfunction

    function automatic bcd_digit_t blank_zero(input bcd_digit_t d);
        return (d == 4'd0) ? BLANK_DIGIT : d;
    endfunction

endpackage

// File: rtl/score_controller_if.sv
// Game-side inputs and renderer-side outputs of the score controller,
// bundled so the game logic and renderer connect through one port.
interface score_controller_if;
    logic       i_v_sync;
    logic       i_scored;
    logic       i_start;
    logic       i_collision;
    logic [1:0] o_state;
    logic [3:0] o_tens;
    logic [3:0] o_units;
    logic [3:0] o_hi_tens;
    logic [3:0] o_hi_units;
    logic       o_new_high;
    logic       o_digits_visible;

    modport master (
        output i_v_sync, i_scored, i_start, i_collision,
        input  o_state, o_tens, o_units, o_hi_tens, o_hi_units,
        input  o_new_high, o_digits_visible
    );

    modport slave (
        input  i_v_sync, i_scored, i_start, i_collision,
        output o_state, o_tens, o_units, o_hi_tens, o_hi_units,
        output o_new_high, o_digits_visible
    );
endinterface

// File: rtl/score_controller_sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge detector;
// an input change shows up as a one-cycle pulse three clocks later.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        meta_d  = i_async;
        sync_d  = meta_q;
        prev_d  = sync_q;
        pulse_d = sync_q & ~prev_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;
endmodule

// File: rtl/score_controller.sv
// Game sequencer owning the displayed score: IDLE/PLAY/OVER control,
// saturating BCD score, high score, frame-aligned display and blink.
module score_controller
    import score_pkg::*;
#(
    parameter int MAX_SCORE    = 99,
    parameter int OVER_FRAMES  = 180,
    parameter int BLINK_FRAMES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    score_controller_if.slave  bus
);
    localparam int FRAME_W = $clog2(OVER_FRAMES);
    localparam int BLINK_W = $clog2(BLINK_FRAMES);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_OVER = OVER;

    localparam bcd2_t MAX_BCD = '{tens: 4'(MAX_SCORE / 10), units: 4'(MAX_SCORE % 10)};
    localparam bcd2_t ZERO_BCD = '{tens: 4'd0, units: 4'd0};
    localparam bcd2_t BLANK_DISP = '{tens: BLANK_DIGIT, units: 4'd0};
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(OVER_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    localparam int IDX_VS = 0;
    localparam int IDX_SC = 1;
    localparam int IDX_ST = 2;
    localparam int IDX_CO = 3;

    logic [3:0] raw_in;
    logic [3:0] pulse;

    assign raw_in = {bus.i_collision, bus.i_start, bus.i_scored, bus.i_v_sync};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            sync_edge_detect u_sync (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_async (raw_in[gi]),
                .o_pulse (pulse[gi])
            );
        end
    endgenerate

    logic vs_p, sc_p, st_p, co_p;
    assign vs_p = pulse[IDX_VS];
    assign sc_p = pulse[IDX_SC];
    assign st_p = pulse[IDX_ST];
    assign co_p = pulse[IDX_CO];

    logic [1:0]         state_q, state_d;
    bcd2_t              score_q, score_d;
    bcd2_t              hi_q, hi_d;
    logic               new_high_q, new_high_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               visible_q, visible_d;
    bcd2_t              disp_score_q, disp_score_d;
    bcd2_t              disp_hi_q, disp_hi_d;

    bcd2_t score_inc;
    bcd2_t score_final;

    always_comb begin
        score_inc = score_q;
        if (bcd2_gt(MAX_BCD, score_q)) begin
            if (score_q.units == 4'd9) begin
                score_inc.units = 4'd0;
                score_inc.tens  = score_q.tens + 4'd1;
            end else begin
                score_inc.units = score_q.units + 4'd1;
            end
        end
        // A collision landing with a score pulse is judged on the bumped score.
        score_final = sc_p ? score_inc : score_q;
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        hi_d         = hi_q;
        new_high_d   = new_high_q;
        frame_d      = frame_q;
        blink_d      = blink_q;
        visible_d    = visible_q;
        disp_score_d = disp_score_q;
        disp_hi_d    = disp_hi_q;

        // Display latches the values held before this cycle's update.
        if (vs_p) begin
            disp_score_d = '{tens: blank_zero(score_q.tens), units: score_q.units};
            disp_hi_d    = '{tens: blank_zero(hi_q.tens), units: hi_q.units};
        end

        case (state_q)
            ST_IDLE: begin
                if (st_p) begin
                    state_d    = ST_PLAY;
                    score_d    = ZERO_BCD;
                    new_high_d = 1'b0;
                end
            end
            ST_PLAY: begin
                score_d = score_final;
                if (co_p) begin
                    state_d   = ST_OVER;
                    frame_d   = '0;
                    blink_d   = '0;
                    visible_d = 1'b1;
                    if (bcd2_gt(score_final, hi_q)) begin
                        hi_d       = score_final;
                        new_high_d = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (vs_p) begin
                    if (frame_q == FRAME_LAST) begin
                        state_d = ST_IDLE;
                        score_d = ZERO_BCD;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                    if (new_high_q) begin
                        if (blink_q == BLINK_LAST) begin
                            blink_d   = '0;
                            visible_d = ~visible_q;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            score_q      <= ZERO_BCD;
            hi_q         <= ZERO_BCD;
            new_high_q   <= 1'b0;
            frame_q      <= '0;
            blink_q      <= '0;
            visible_q    <= 1'b1;
            disp_score_q <= BLANK_DISP;
            disp_hi_q    <= BLANK_DISP;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            new_high_q   <= new_high_d;
            frame_q      <= frame_d;
            blink_q      <= blink_d;
            visible_q    <= visible_d;
            disp_score_q <= disp_score_d;
            disp_hi_q    <= disp_hi_d;
        end
    end

    assign bus.o_state          = state_q;
    assign bus.o_tens           = disp_score_q.tens;
    assign bus.o_units          = disp_score_q.units;
    assign bus.o_hi_tens        = disp_hi_q.tens;
    assign bus.o_hi_units       = disp_hi_q.units;
    assign bus.o_new_high       = new_high_q;
    assign bus.o_digits_visible = (state_q == ST_OVER && new_high_q) ? visible_q : 1'b1;
endmodule

// File: tb/tb_score_controller.sv
// Scoreboard bench: the driver updates an integer game model and queues the
// expected display for each frame; a monitor checks it after each v-sync.
module tb_score_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    score_controller_if bus ();

    score_controller #(
        .MAX_SCORE    (99),
        .OVER_FRAMES  (180),
        .BLINK_FRAMES (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        int tens;
        int units;
        int hi_tens;
        int hi_units;
        int state;
        int nh;
        int vis;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int frame_no = 0;

    // Game model in plain integers.
    int m_state;
    int m_score;
    int m_hi;
    int m_nh;
    int m_over_n;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int shown_tens(input int s);
        return (s / 10 == 0) ? 15 : s / 10;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_score  = 0;
        m_hi     = 0;
        m_nh     = 0;
        m_over_n = 0;
    endtask

    task automatic drive(input logic [3:0] mask);
        @(negedge clk);
        bus.i_v_sync    = mask[0];
        bus.i_scored    = mask[1];
        bus.i_start     = mask[2];
        bus.i_collision = mask[3];
        repeat (4) @(negedge clk);
        bus.i_v_sync    = 1'b0;
        bus.i_scored    = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_collision = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_scored();
        if (m_state == 1 && m_score < 99) m_score++;
        drive(4'b0010);
    endtask

    task automatic do_start();
        if (m_state == 0) begin
            m_state = 1;
            m_score = 0;
            m_nh    = 0;
        end
        drive(4'b0100);
    endtask

    task automatic do_collision(input bit with_score);
        if (m_state == 1) begin
            if (with_score && m_score < 99) m_score++;
            m_state  = 2;
            m_over_n = 0;
            if (m_score > m_hi) begin
                m_hi = m_score;
                m_nh = 1;
            end
        end
        drive(with_score ? 4'b1010 : 4'b1000);
    endtask

    task automatic do_vsync();
        exp_t e;
        e.tens     = shown_tens(m_score);
        e.units    = m_score % 10;
        e.hi_tens  = shown_tens(m_hi);
        e.hi_units = m_hi % 10;
        if (m_state == 2) begin
            m_over_n++;
            if (m_over_n == 180) begin
                m_state = 0;
                m_score = 0;
            end
        end
        e.state = m_state;
        e.nh    = m_nh;
        e.vis   = (m_state == 2 && m_nh == 1) ? (((m_over_n / 16) % 2 == 0) ? 1 : 0) : 1;
        exp_q.push_back(e);
        drive(4'b0001);
    endtask

    task automatic vsyncs(input int n);
        for (int i = 0; i < n; i++) do_vsync();
    endtask

    task automatic score_n(input int n);
        for (int i = 0; i < n; i++) begin
            do_scored();
            if ($urandom_range(0, 3) == 0) do_vsync();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"},    int'(bus.o_state), 0);
        chk({tag, "_tens"},     int'(bus.o_tens), 15);
        chk({tag, "_units"},    int'(bus.o_units), 0);
        chk({tag, "_hi_tens"},  int'(bus.o_hi_tens), 15);
        chk({tag, "_hi_units"}, int'(bus.o_hi_units), 0);
        chk({tag, "_new_high"}, int'(bus.o_new_high), 0);
        chk({tag, "_visible"},  int'(bus.o_digits_visible), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge bus.i_v_sync);
            repeat (6) @(negedge clk);
            frame_no++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: frame %0d had no expectation", frame_no);
            end else begin
                e = exp_q.pop_front();
                $display("frame %0d: state=%0d score=%h%h hi=%h%h new_high=%0d visible=%0d",
                         frame_no, bus.o_state, bus.o_tens, bus.o_units,
                         bus.o_hi_tens, bus.o_hi_units, bus.o_new_high, bus.o_digits_visible);
                chk("tens",     int'(bus.o_tens), e.tens);
                chk("units",    int'(bus.o_units), e.units);
                chk("hi_tens",  int'(bus.o_hi_tens), e.hi_tens);
                chk("hi_units", int'(bus.o_hi_units), e.hi_units);
                chk("state",    int'(bus.o_state), e.state);
                chk("new_high", int'(bus.o_new_high), e.nh);
                chk("visible",  int'(bus.o_digits_visible), e.vis);
            end
        end
    end

    initial begin : driver
        bus.i_v_sync    = 1'b0;
        bus.i_scored    = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_collision = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Scoring in IDLE is ignored.
        score_n(5);
        do_vsync();

        // First game: 12 points, then run to saturation.
        do_start();
        score_n(12);
        do_vsync();
        score_n(86);
        do_vsync();
        score_n(3);
        do_vsync();
        do_collision(1'b0);
        vsyncs(181);

        // Fresh high score from a same-cycle score+collision at 07.
        do_reset();
        do_start();
        score_n(7);
        do_collision(1'b1);
        vsyncs(181);

        // Game that does not beat the high score: no blink.
        do_start();
        score_n(5);
        do_collision(1'b0);
        vsyncs(181);

        // Randomised games, with ignored pulses poked into OVER.
        repeat (2) begin
            do_start();
            score_n($urandom_range(0, 110));
            do_collision(1'($urandom_range(0, 1)));
            vsyncs(60);
            do_scored();
            do_start();
            vsyncs(121);
        end

        // Reset in the middle of play at 42 with a high score of 30.
        do_reset();
        do_start();
        score_n(30);
        do_collision(1'b0);
        vsyncs(181);
        do_start();
        score_n(42);
        do_vsync();
        do_reset();

        repeat (10) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_left: %0d expectations never checked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Clocked game/score sequencer that owns the score value shown by the score sprite renderer.
- Synchronises the raw score pulse and v-sync into i_clk and runs the IDLE/PLAY/OVER game state machine.
- Keeps a saturating 2-digit BCD score and a high score.
- Presents digit codes to the renderer only at frame boundaries, so a frame never tears mid-scan.
- Replaces the edge-triggered, unclocked counting currently done inside the renderer; the renderer becomes a pure digit-code-to-glyph lookup.

Parameters:
- MAX_SCORE, 99, saturation value (BCD, ≤ 99).
- OVER_FRAMES, 180, frames spent in OVER before returning to IDLE (3 s at 60 Hz).
- BLINK_FRAMES, 16, frames per blink half-period for a new high score.

Ports:
- i_clk  in  1  pixel/system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_v_sync  in  1  raw v-sync level; a frame boundary is its synchronised rising edge.
- i_scored  in  1  raw score strobe from game logic; each rising edge = +1.
- i_start  in  1  start request (level); rising edge acts.
- i_collision  in  1  game-over request (level); rising edge acts.
- o_state  out  2  0=IDLE, 1=PLAY, 2=OVER.
- o_tens  out  4  displayed tens digit code; 4'hF = blank.
- o_units  out  4  displayed units digit code 0-9.
- o_hi_tens  out  4  displayed high-score tens code; 4'hF = blank.
- o_hi_units  out  4  displayed high-score units code.
- o_new_high  out  1  set when the last game beat the high score.
- o_digits_visible  out  1  blink gate for the score digits.

Behaviour:
- Reset (async, i_rst=1), all outputs and state:
  - State IDLE; score = 00; high score = 00.
  - o_tens = 4'hF, o_units = 0, o_hi_tens = 4'hF, o_hi_units = 0.
  - o_new_high = 0, o_digits_visible = 1; frame and blink counters = 0.
  - Reset asserted mid-game behaves identically; the high score is not retained.
- Input conditioning:
  - All four inputs pass through 2-flop synchronisers, then a rising-edge detect (one-cycle pulse).
  - Input-to-pulse latency is 3 i_clk cycles.
  - A level held high counts once.
- IDLE:
  - Score held at 00.
  - start pulse → PLAY; on the same edge clear score and o_new_high.
  - scored and collision pulses are ignored.
- PLAY:
  - A scored pulse increments the BCD score: units 9 → 0 with tens+1.
  - At MAX_SCORE the score saturates and stays; no wrap.
  - A collision pulse → OVER.
  - start pulses are ignored.
- Scored and collision pulses in the same cycle:
  - The increment is applied first; the OVER entry compare uses the incremented score.
- Entry to OVER (registered on the transition edge):
  - If score > high score: high score ← score and o_new_high ← 1.
  - Frame counter cleared.
- OVER:
  - Score frozen; scored and start pulses ignored.
  - The frame counter increments on each v-sync pulse.
  - When it reaches OVER_FRAMES-1 and another v-sync pulse arrives → IDLE. o_new_high persists until the next start.
- Display update:
  - o_tens/o_units/o_hi_* load from the internal registers only on a v-sync pulse cycle, in every state.
  - Leading zero suppressed: tens digit 0 is output as 4'hF; units is always shown.
  - If the score changes on the same cycle as the v-sync pulse, the display takes the pre-increment value; the new value appears at the next frame.
- Blink:
  - Applies in OVER with o_new_high=1: o_digits_visible toggles every BLINK_FRAMES v-sync pulses, starting at 1 on OVER entry.
  - Otherwise o_digits_visible = 1.
- Width rules:
  - All score arithmetic is per-digit 4-bit BCD; no binary intermediate.
  - Comparison is tens-first, then units.
  - Frame counter is $clog2(OVER_FRAMES) bits; blink counter is $clog2(BLINK_FRAMES) bits.

Decomposition:
- Package score_pkg:
  - game_state_t enum (IDLE, PLAY, OVER).
  - BLANK_DIGIT = 4'hF.
  - bcd_digit_t (4-bit).
  - bcd2_t struct {tens, units}.
  - Function bcd2_gt for the tens-first compare.
- Sub-module sync_edge_detect: 2-flop synchroniser plus rising-edge pulse, with async active-high reset. Instantiated four times.
- The BCD increment/saturate logic stays inline.

Test Plan:
- Reset, then 5 scored edges while IDLE → score stays 00; o_tens=F, o_units=0 after the next v-sync.
- start edge, then 12 scored edges → after the next v-sync: o_tens=1, o_units=2, o_state=1.
- In PLAY from 98, 3 scored edges → display 9/9, no wrap.
- Scored and collision edges aligned to the same i_clk cycle at score 07 → OVER; hi=08, o_new_high=1; o_digits_visible toggles after 16 v-syncs; o_state=0 after 180 v-syncs.
- Second game scoring 05 with hi=08 → o_new_high=0, hi remains 0/8; no blinking in OVER.
- Assert i_rst mid-PLAY at score 42 with hi 30 → all outputs return to reset values immediately, without a clock edge.
